// File: rtl/sram_march_bist_if.sv
// Shared SRAM macro bus: per-bank chip enables, shared address/data/write enables.
// Master side is the BIST engine, slave side is the macro bank array.
interface sram_march_bist_if #(
   parameter int NUM_BANKS = 2,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 8
);
   logic [NUM_BANKS-1:0]        sram_cen;
   logic                        sram_gwen;
   logic [DATA_W-1:0]           sram_wen;
   logic [ADDR_W-1:0]           sram_a;
   logic [DATA_W-1:0]           sram_d;
   logic [NUM_BANKS*DATA_W-1:0] sram_q;

   modport master (
      output sram_cen, sram_gwen, sram_wen,
      output sram_a, sram_d,
      input  sram_q
   );

   modport slave (
      input  sram_cen, sram_gwen, sram_wen,
      input  sram_a, sram_d,
      output sram_q
   );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST over NUM_BANKS single-port SRAM macros, one bank at a time.
// Optional BIST_STOP_ON_FAIL_EN: first mismatch ends the run in DONE.
module sram_march_bist #(
   parameter int NUM_BANKS = 2,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 8,
   parameter logic [DATA_W-1:0] PATTERN = '0,
   parameter int ERR_W     = 16,
   localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   sram_march_bist_if.master    mem,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_W-1:0]     err_count,
   output logic [BANK_W-1:0]    fail_bank,
   output logic [ADDR_W-1:0]    fail_addr,
   output logic [2:0]           fail_elem
);
   localparam logic [ADDR_W-1:0] A_MAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state;
   logic [BANK_W-1:0]   bank;
   logic [2:0]          elem;
   logic [ADDR_W-1:0]   addr;
   logic                ph;

   logic                cmp_vld;
   logic [DATA_W-1:0]   cmp_exp;
   logic [BANK_W-1:0]   cmp_bank;
   logic [ADDR_W-1:0]   cmp_addr;
   logic [2:0]          cmp_elem;

   logic                rw, down, at_end, bank_end;
   logic                cur_rd, last_bank, issue;
   logic [DATA_W-1:0]   cur_rexp;
   logic [2:0]          nx_e;
   logic [ADDR_W-1:0]   nx_a;
   logic                nx_ph, nx_wr;
   logic [BANK_W-1:0]   nx_bank;
   logic [DATA_W-1:0]   nx_wd;
   logic [DATA_W-1:0]   q_sel;
   logic                mism, stop_hit;
   logic [ERR_W-1:0]    err_nx;

   // ph=0 is the read half, ph=1 the write half of a read-write element
   always_comb begin
      rw       = (elem >= 3'd1) && (elem <= 3'd4);
      down     = (elem == 3'd3) || (elem == 3'd4);
      at_end   = down ? (addr == '0) : (addr == A_MAX);
      bank_end = (elem == 3'd5) && at_end;
      cur_rd   = (elem == 3'd5) || (rw && !ph);
      cur_rexp = ((elem == 3'd2) || (elem == 3'd4))
                 ? ~PATTERN : PATTERN;
      last_bank = (bank == BANK_W'(NUM_BANKS - 1));
      nx_e    = elem;
      nx_a    = addr;
      nx_ph   = 1'b0;
      nx_bank = bank;
      if (state != RUN) begin
         nx_e    = '0;
         nx_a    = '0;
         nx_bank = (state == DRAIN) ? bank + 1'b1 : '0;
      end else if (rw && !ph) begin
         nx_ph = 1'b1;
      end else if (!at_end) begin
         nx_a = down ? addr - 1'b1 : addr + 1'b1;
      end else begin
         nx_e = elem + 3'd1;
         nx_a = ((elem == 3'd2) || (elem == 3'd3)) ? A_MAX : '0;
      end
      nx_wr = (nx_e == 3'd0) ||
              ((nx_e >= 3'd1) && (nx_e <= 3'd4) && nx_ph);
      nx_wd = ((nx_e == 3'd1) || (nx_e == 3'd3))
              ? ~PATTERN : PATTERN;
   end

   // read data is compared in the cycle after its access edge
   always_comb begin
      q_sel  = mem.sram_q[int'(cmp_bank)*DATA_W +: DATA_W];
      mism   = cmp_vld && (q_sel != cmp_exp);
      err_nx = (mism && (err_count != '1))
               ? err_count + 1'b1 : err_count;
   end

`ifdef BIST_STOP_ON_FAIL_EN
   assign stop_hit = mism;
`else
   assign stop_hit = 1'b0;
`endif

   always_comb begin
      unique case (state)
         IDLE, DONE: issue = start;
         RUN:        issue = !bank_end && !stop_hit;
         DRAIN:      issue = !last_bank && !stop_hit;
         default:    issue = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bank          <= '0;
         elem          <= '0;
         addr          <= '0;
         ph            <= 1'b0;
         cmp_vld       <= 1'b0;
         cmp_exp       <= '0;
         cmp_bank      <= '0;
         cmp_addr      <= '0;
         cmp_elem      <= '0;
         mem.sram_cen  <= '1;
         mem.sram_gwen <= 1'b1;
         mem.sram_wen  <= '1;
         mem.sram_a    <= '0;
         mem.sram_d    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         fail_bank     <= '0;
         fail_addr     <= '0;
         fail_elem     <= '0;
      end else if (abort) begin
         state         <= IDLE;
         cmp_vld       <= 1'b0;
         mem.sram_cen  <= '1;
         mem.sram_gwen <= 1'b1;
         mem.sram_wen  <= '1;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
      end else begin
         err_count <= err_nx;
         if (mism && (err_count == '0)) begin
            fail_bank <= cmp_bank;
            fail_addr <= cmp_addr;
            fail_elem <= cmp_elem;
         end
         cmp_vld  <= (state == RUN) && cur_rd && !stop_hit;
         cmp_exp  <= cur_rexp;
         cmp_bank <= bank;
         cmp_addr <= addr;
         cmp_elem <= elem;
         if (issue) begin
            state         <= RUN;
            busy          <= 1'b1;
            bank          <= nx_bank;
            elem          <= nx_e;
            addr          <= nx_a;
            ph            <= nx_ph;
            mem.sram_cen  <= ~(NUM_BANKS'(1) << nx_bank);
            mem.sram_gwen <= !nx_wr;
            mem.sram_wen  <= nx_wr ? '0 : '1;
            mem.sram_a    <= nx_a;
            mem.sram_d    <= nx_wr ? nx_wd : '0;
         end else if ((state == RUN) || (state == DRAIN)) begin
            mem.sram_cen  <= '1;
            mem.sram_gwen <= 1'b1;
            mem.sram_wen  <= '1;
            if ((state == RUN) && !stop_hit) begin
               state <= DRAIN;
            end else begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (err_nx == '0);
            end
         end
         if (((state == IDLE) || (state == DONE)) && start) begin
            err_count <= '0;
            fail_bank <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: behavioural macro model plus access scoreboard.
// Expectations follow BIST_STOP_ON_FAIL_EN when it is defined.
module tb_sram_march_bist;
   localparam int NB = 2;
   localparam int AW = 3;
   localparam int DW = 8;
   localparam int EW = 2;
   localparam logic [DW-1:0] PAT = 8'h00;

   logic clk = 1'b0;
   logic rst, start, abort;
   logic busy, done, pass;
   logic [EW-1:0] err_count;
   logic [0:0]    fail_bank;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;

   sram_march_bist_if #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_march_bist #(
      .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW),
      .PATTERN(PAT), .ERR_W(EW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .mem(bus), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_bank(fail_bank),
      .fail_addr(fail_addr), .fail_elem(fail_elem)
   );

   always #5 clk = ~clk;

   // behavioural 1-cycle-latency macros; optional stuck-at-0 cell and forced Q
   logic [DW-1:0] mem_arr [NB][2**AW];
   logic [DW-1:0] q_r [NB];
   bit stuck, force_a5, mon_en;

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (!bus.sram_cen[b]) begin
            if (!bus.sram_gwen)
               mem_arr[b][bus.sram_a] <= (bus.sram_d & ~bus.sram_wen) |
                                         (mem_arr[b][bus.sram_a] & bus.sram_wen);
            else
               q_r[b] <= mem_arr[b][bus.sram_a] &
                         ((stuck && b == 1 && bus.sram_a == 3'd5) ? 8'hFE : 8'hFF);
         end
      end
   end

   assign bus.sram_q = {q_r[1], force_a5 ? 8'hA5 : q_r[0]};

   int nchk = 0;
   int npass = 0;
   int nfail = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard entry: {cen, addr, gwen, write data (0 on reads)}
   logic [13:0] sb[$];

   task automatic push_one(input int b, input int a, input bit gw,
                           input logic [DW-1:0] d);
      logic [1:0] c;
      logic [AW-1:0] av;
      c = 2'b11;
      c[b] = 1'b0;
      av = AW'(a);
      sb.push_back({c, av, gw, gw ? 8'h00 : d});
   endtask

   task automatic push_elem(input int b, input bit dn, input bit rd,
                            input bit wr, input logic [DW-1:0] wd);
      for (int i = 0; i < 2**AW; i++) begin
         int a;
         a = dn ? (2**AW - 1 - i) : i;
         if (rd) push_one(b, a, 1'b1, 8'h00);
         if (wr) push_one(b, a, 1'b0, wd);
      end
   endtask

   task automatic push_bank(input int b);
      push_elem(b, 1'b0, 1'b0, 1'b1, PAT);
      push_elem(b, 1'b0, 1'b1, 1'b1, ~PAT);
      push_elem(b, 1'b0, 1'b1, 1'b1, PAT);
      push_elem(b, 1'b1, 1'b1, 1'b1, ~PAT);
      push_elem(b, 1'b1, 1'b1, 1'b1, PAT);
      push_elem(b, 1'b0, 1'b1, 1'b0, PAT);
   endtask

   always @(negedge clk) begin
      if (mon_en && bus.sram_cen != 2'b11) begin
         logic [13:0] obs;
         obs = {bus.sram_cen, bus.sram_a, bus.sram_gwen,
                bus.sram_gwen ? 8'h00 : bus.sram_d};
         if (sb.size() == 0) check("sb_extra_access", obs, 14'h3FFF);
         else check("sb_access", obs, sb.pop_front());
      end
   end

   task automatic run_bist(output int cyc);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 400) begin
         if (busy) cyc++;
         @(negedge clk);
      end
   endtask

   int cyc;
   int exp_cyc;
   logic [EW-1:0] exp_err;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      stuck = 0; force_a5 = 0; mon_en = 0;
      repeat (2) @(negedge clk);
      check("rst_cen", bus.sram_cen, 2'b11);
      check("rst_gwen", bus.sram_gwen, 1'b1);
      check("rst_wen", bus.sram_wen, 8'hFF);
      check("rst_a", bus.sram_a, 3'd0);
      check("rst_d", bus.sram_d, 8'h00);
      check("rst_status", {busy, done, pass}, 3'b000);
      check("rst_err", err_count, 2'd0);
      check("rst_fail", {fail_bank, fail_addr, fail_elem}, 7'd0);
      rst = 1'b0;

      // clean run with full access-order scoreboard
      push_bank(0);
      push_bank(1);
      mon_en = 1;
      run_bist(cyc);
      mon_en = 0;
      check("clean_cycles", cyc, 162);
      check("clean_done", {done, pass, busy}, 3'b110);
      check("clean_err", err_count, 2'd0);
      check("clean_sb_left", sb.size(), 0);
      check("clean_cen", bus.sram_cen, 2'b11);

      // stuck-at-0 at bank 1, addr 5, bit 0
      stuck = 1;
`ifdef BIST_STOP_ON_FAIL_EN
      exp_cyc = 117; exp_err = 2'd1;
`else
      exp_cyc = 162; exp_err = 2'd2;
`endif
      run_bist(cyc);
      check("stuck_cycles", cyc, exp_cyc);
      check("stuck_done", {done, pass, busy}, 3'b100);
      check("stuck_err", err_count, exp_err);
      check("stuck_bank", fail_bank, 1'b1);
      check("stuck_addr", fail_addr, 3'd5);
      check("stuck_elem", fail_elem, 3'd2);
      check("stuck_cen", bus.sram_cen, 2'b11);
      stuck = 0;

      // bank 0 Q forced to A5: every bank-0 read mismatches
      force_a5 = 1;
`ifdef BIST_STOP_ON_FAIL_EN
      exp_cyc = 10; exp_err = 2'd1;
`else
      exp_cyc = 162; exp_err = 2'd3;
`endif
      run_bist(cyc);
      check("sat_cycles", cyc, exp_cyc);
      check("sat_done", {done, pass}, 2'b10);
      check("sat_err", err_count, exp_err);
      check("sat_bank", fail_bank, 1'b0);
      check("sat_addr", fail_addr, 3'd0);
      check("sat_elem", fail_elem, 3'd1);
      force_a5 = 0;

      // abort around cycle 40, with start also high (abort wins)
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      check("pre_abort_busy", busy, 1'b1);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("abort_status", {busy, done, pass}, 3'b000);
      check("abort_cen", bus.sram_cen, 2'b11);
      check("abort_err_kept", err_count, 2'd0);
      @(negedge clk);
      check("abort_stays_idle", busy, 1'b0);
      run_bist(cyc);
      check("rerun_cycles", cyc, 162);
      check("rerun_done", {done, pass}, 2'b11);
      check("rerun_err", err_count, 2'd0);

      // asynchronous reset mid-run
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_status", {busy, done, pass}, 3'b000);
      check("arst_cen", bus.sram_cen, 2'b11);
      check("arst_gwen", bus.sram_gwen, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
